// File: rtl/bias_add_quant_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bias_add_quant_pkg
//  Description : Shared constants and helpers for the bias-add / requantise
//                path: lane slicing, output saturation bounds and the common
//                round / shift / ReLU / saturate function.
//  Revision    : 1.0 - initial release
// ============================================================================
package bias_add_quant_pkg;

    localparam int C_LANES   = 8;
    localparam int C_ACC_W   = 32;
    localparam int C_BIAS_W  = 32;
    localparam int C_OUT_W   = 8;
    localparam int C_SHIFT_W = 5;

    // Internal arithmetic width, wide enough for any sum plus rounding growth.
    localparam int C_CALC_W  = 72;

    typedef logic signed [C_CALC_W-1:0] calc_t;

    // Low bit index of lane 'lane' in a bus of 'width'-bit lanes.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

    // Largest value representable in a signed out_w-bit result.
    function automatic calc_t sat_max(input int out_w);
        return (calc_t'(1) <<< (out_w - 1)) - calc_t'(1);
    endfunction

    // Smallest value representable in a signed out_w-bit result.
    function automatic calc_t sat_min(input int out_w);
        return -(calc_t'(1) <<< (out_w - 1));
    endfunction

    // Round-half-up, arithmetic right shift, optional ReLU, saturate.
    function automatic calc_t requant(input calc_t       sum,
                                      input int unsigned shift,
                                      input logic        relu,
                                      input int          out_w);
        calc_t r;
        r = sum;
        if (shift != 0) begin
            r = r + (calc_t'(1) <<< (shift - 1));
        end
        r = r >>> shift;
        if (relu && r[C_CALC_W-1]) begin
            r = '0;
        end
        if (r > sat_max(out_w)) begin
            r = sat_max(out_w);
        end else if (r < sat_min(out_w)) begin
            r = sat_min(out_w);
        end
        return r;
    endfunction

endpackage : bias_add_quant_pkg
`default_nettype wire

// File: rtl/bias_pingpong_buf.sv
`default_nettype none
// ============================================================================
//  Module      : bias_pingpong_buf
//  Description : Two-slot ping-pong buffer for per-group bias vectors. A slot
//                stays readable for every beat of its group and is released
//                when the group's last beat is consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module bias_pingpong_buf
    import bias_add_quant_pkg::*;
#(
    parameter int LANES  = C_LANES,
    parameter int BIAS_W = C_BIAS_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    push_valid,
    input  logic [LANES*BIAS_W-1:0] push_data,
    output logic                    push_ready,
    input  logic                    pop,
    output logic                    not_empty,
    output logic [LANES*BIAS_W-1:0] rd_data
);

    logic [LANES*BIAS_W-1:0] r_slot [2];
    logic                    r_wr_ptr;
    logic                    r_rd_ptr;
    logic [1:0]              r_count;
    logic                    w_push;
    logic                    w_pop;

    assign push_ready = (r_count < 2'd2);
    assign not_empty  = (r_count != 2'd0);
    assign w_push     = push_valid && push_ready && !clear;
    assign w_pop      = pop && not_empty && !clear;
    assign rd_data    = r_slot[r_rd_ptr];

    // Bias slot storage, written at the write pointer on each push.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
        end else if (w_push) begin
            r_slot[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; a flush empties the buffer and drops handshakes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (clear) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : bias_pingpong_buf
`default_nettype wire

// File: rtl/bias_add_quant.sv
`default_nettype none
// ============================================================================
//  Module      : bias_add_quant
//  Description : Adds a buffered per-group bias to the accumulator stream,
//                then rounds, shifts, optionally applies ReLU and saturates
//                each lane to OUT_W bits. Two register stages, 1 beat/cycle,
//                valid/ready on the accumulator and output sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module bias_add_quant
    import bias_add_quant_pkg::*;
#(
    parameter int LANES   = C_LANES,
    parameter int ACC_W   = C_ACC_W,
    parameter int BIAS_W  = C_BIAS_W,
    parameter int OUT_W   = C_OUT_W,
    parameter int SHIFT_W = C_SHIFT_W
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_start,
    input  logic [SHIFT_W-1:0]      cfg_shift,
    input  logic                    cfg_relu,
    input  logic                    bias_valid,
    input  logic [LANES*BIAS_W-1:0] bias_data,
    output logic                    bias_ready,
    input  logic                    acc_valid,
    input  logic [LANES*ACC_W-1:0]  acc_data,
    input  logic                    acc_last,
    output logic                    acc_ready,
    output logic                    out_valid,
    output logic [LANES*OUT_W-1:0]  out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    group_done
);

    localparam int C_SUM_W = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;

    logic                     w_buf_not_empty;
    logic [LANES*BIAS_W-1:0]  w_bias_vec;
    logic                     w_adv;
    logic                     w_acc_take;
    logic                     w_pop;
    logic [LANES*C_SUM_W-1:0] w_sum;
    logic [LANES*OUT_W-1:0]   w_q;

    logic                     r_s1_valid;
    logic                     r_s1_last;
    logic [LANES*C_SUM_W-1:0] r_s1_sum;
    logic                     r_s2_valid;
    logic                     r_s2_last;
    logic [LANES*OUT_W-1:0]   r_s2_data;

    // The whole pipe moves together; it only freezes when the output is blocked.
    assign w_adv      = !r_s2_valid || out_ready;
    assign acc_ready  = w_buf_not_empty && w_adv;
    assign w_acc_take = acc_valid && acc_ready && !cfg_start;
    assign w_pop      = w_acc_take && acc_last;

    bias_pingpong_buf #(
        .LANES  (LANES),
        .BIAS_W (BIAS_W)
    ) u_bias_buf (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (cfg_start),
        .push_valid (bias_valid),
        .push_data  (bias_data),
        .push_ready (bias_ready),
        .pop        (w_pop),
        .not_empty  (w_buf_not_empty),
        .rd_data    (w_bias_vec)
    );

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic signed [ACC_W-1:0]   w_acc_l;
            logic signed [BIAS_W-1:0]  w_bias_l;
            logic signed [C_SUM_W-1:0] w_s1_l;

            assign w_acc_l  = acc_data[lane_lo(i, ACC_W) +: ACC_W];
            assign w_bias_l = w_bias_vec[lane_lo(i, BIAS_W) +: BIAS_W];
            assign w_sum[lane_lo(i, C_SUM_W) +: C_SUM_W] =
                C_SUM_W'(w_acc_l) + C_SUM_W'(w_bias_l);

            assign w_s1_l = r_s1_sum[lane_lo(i, C_SUM_W) +: C_SUM_W];
            assign w_q[lane_lo(i, OUT_W) +: OUT_W] =
                OUT_W'(requant(calc_t'(w_s1_l), 32'(cfg_shift), cfg_relu, OUT_W));
        end
    endgenerate

    // S1 captures the biased sum, S2 the requantised result; flush clears both.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sum   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
        end else if (cfg_start) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_sum   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_last  <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_acc_take;
            r_s1_last  <= w_acc_take && acc_last;
            r_s1_sum   <= w_sum;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_data  <= w_q;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_data   = r_s2_data;
    assign out_last   = r_s2_last;
    assign group_done = r_s2_valid && out_ready && r_s2_last;

endmodule : bias_add_quant
`default_nettype wire

// File: tb/tb_bias_add_quant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bias_add_quant
//  Description : Self-checking bench for bias_add_quant with an arithmetic
//                reference model and expected-output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_add_quant;

    localparam int LANES  = 8;
    localparam int ACC_W  = 32;
    localparam int BIAS_W = 32;
    localparam int OUT_W  = 8;
    localparam longint HI = (longint'(1) << (OUT_W - 1)) - 1;
    localparam longint LO = -(longint'(1) << (OUT_W - 1));

    typedef struct {
        logic [LANES*OUT_W-1:0] data;
        logic                   last;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    cfg_start;
    logic [4:0]              cfg_shift;
    logic                    cfg_relu;
    logic                    bias_valid;
    logic [LANES*BIAS_W-1:0] bias_data;
    logic                    bias_ready;
    logic                    acc_valid;
    logic [LANES*ACC_W-1:0]  acc_data;
    logic                    acc_last;
    logic                    acc_ready;
    logic                    out_valid;
    logic [LANES*OUT_W-1:0]  out_data;
    logic                    out_last;
    logic                    out_ready;
    logic                    group_done;

    int checks;
    int failures;
    int gd_cnt;
    bit rand_ready;

    logic [LANES*BIAS_W-1:0] bq[$];
    exp_t                    eq[$];

    bias_add_quant dut (
        .clk        (clk),
        .rstn       (rstn),
        .cfg_start  (cfg_start),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .bias_valid (bias_valid),
        .bias_data  (bias_data),
        .bias_ready (bias_ready),
        .acc_valid  (acc_valid),
        .acc_data   (acc_data),
        .acc_last   (acc_last),
        .acc_ready  (acc_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .group_done (group_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer sum, round half up, floor division, relu, clamp.
    function automatic logic [LANES*OUT_W-1:0] model_vec(input logic [LANES*ACC_W-1:0] a,
                                                        input logic [LANES*BIAS_W-1:0] b,
                                                        input int sh, input bit relu);
        logic [LANES*OUT_W-1:0] res;
        logic [31:0] la, lb;
        longint s, d, q;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            la = a[i*ACC_W +: ACC_W];
            lb = b[i*BIAS_W +: BIAS_W];
            s  = longint'(signed'(la)) + longint'(signed'(lb));
            d  = longint'(1) << sh;
            if (sh > 0) s = s + d / 2;
            q = s / d;
            if ((s % d != 0) && (s < 0)) q = q - 1;
            if (relu && q < 0) q = 0;
            if (q > HI) q = HI;
            if (q < LO) q = LO;
            res[i*OUT_W +: OUT_W] = q[OUT_W-1:0];
        end
        return res;
    endfunction

    function automatic logic [255:0] fill(input int v);
        logic [255:0] r;
        for (int i = 0; i < LANES; i++) r[i*32 +: 32] = 32'(v);
        return r;
    endfunction

    function automatic logic [255:0] rnd_vec();
        logic [255:0] r;
        logic [31:0]  v;
        for (int i = 0; i < LANES; i++) begin
            v = $urandom;
            v = signed'(v) >>> $urandom_range(0, 26);
            r[i*32 +: 32] = v;
        end
        return r;
    endfunction

    // Scoreboard: observes handshakes between edges, predicts every output beat.
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            bq.delete();
            eq.delete();
        end else begin
            chk("bias_ready_vs_count", 64'(bias_ready), 64'(bq.size() < 2));
            if (bq.size() == 0 || (out_valid && !out_ready))
                chk("acc_ready_blocked", 64'(acc_ready), 64'd0);
            if (out_valid && out_ready) begin
                chk("out_expected_present", 64'(eq.size() != 0), 64'd1);
                if (eq.size() != 0) begin
                    e = eq.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.data));
                    chk("out_last", 64'(out_last), 64'(e.last));
                    chk("group_done_on_beat", 64'(group_done), 64'(e.last));
                end
            end else begin
                chk("group_done_idle", 64'(group_done), 64'd0);
            end
            if (group_done) gd_cnt++;
            if (cfg_start) begin
                bq.delete();
                eq.delete();
            end else begin
                if (acc_valid && acc_ready && bq.size() != 0) begin
                    e.data = model_vec(acc_data, bq[0], int'(cfg_shift), cfg_relu);
                    e.last = acc_last;
                    eq.push_back(e);
                    if (acc_last) void'(bq.pop_front());
                end
                if (bias_valid && bias_ready) bq.push_back(bias_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_bias(input logic [255:0] b);
        int n;
        bit hs;
        bias_valid = 1'b1;
        bias_data  = b;
        n = 0;
        do begin
            @(negedge clk);
            hs = bias_ready;
            tick();
            n++;
        end while (!hs && n < 200);
        bias_valid = 1'b0;
        chk("push_bias_handshake", 64'(hs), 64'd1);
    endtask

    task automatic send_beat(input logic [255:0] a, input logic last);
        int n;
        bit hs;
        acc_valid = 1'b1;
        acc_data  = a;
        acc_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            hs = acc_ready;
            tick();
            n++;
        end while (!hs && n < 200);
        acc_valid = 1'b0;
        acc_last  = 1'b0;
        chk("send_beat_handshake", 64'(hs), 64'd1);
    endtask

    task automatic wait_out(input logic [63:0] exp, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk(tag, 64'(out_data), exp);
        tick();
    endtask

    task automatic drain();
        int n;
        out_ready  = 1'b1;
        rand_ready = 1'b0;
        n = 0;
        while ((eq.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(eq.size()), 64'd0);
        tick();
    endtask

    initial begin
        logic [255:0] va, vb, vs, c;
        logic [255:0] a1, a2, a3, a4;
        int nb;

        checks = 0; failures = 0; gd_cnt = 0; rand_ready = 1'b0;
        rstn = 1'b0; cfg_start = 1'b0; cfg_shift = 5'd4; cfg_relu = 1'b0;
        bias_valid = 1'b0; bias_data = '0;
        acc_valid = 1'b0; acc_data = '0; acc_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        // Reset asserted in the middle of a stream
        push_bias(rnd_vec());
        send_beat(rnd_vec(), 1'b0);
        acc_valid = 1'b1; acc_data = rnd_vec(); acc_last = 1'b0;
        tick();
        rstn = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_acc_ready", 64'(acc_ready), 64'd0);
        chk("rst_bias_ready", 64'(bias_ready), 64'd1);
        tick();
        tick();
        rstn = 1'b1;
        acc_valid = 1'b1; acc_data = fill(1000); acc_last = 1'b1;
        @(negedge clk);
        chk("post_rst_bias_ready", 64'(bias_ready), 64'd1);
        chk("post_rst_acc_ready", 64'(acc_ready), 64'd0);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        chk("post_rst_out_last", 64'(out_last), 64'd0);
        chk("post_rst_group_done", 64'(group_done), 64'd0);
        tick();
        bias_valid = 1'b1; bias_data = fill(100);
        @(negedge clk);
        chk("no_accept_during_first_push", 64'(acc_ready), 64'd0);
        tick();
        bias_valid = 1'b0;
        @(negedge clk);
        chk("accept_after_push", 64'(acc_ready), 64'd1);
        tick();
        acc_valid = 1'b0; acc_last = 1'b0;
        @(negedge clk);
        chk("lat_n1_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_n2_out_valid", 64'(out_valid), 64'd1);
        chk("basic_1100_sh4", 64'(out_data), 64'h4545454545454545);
        chk("basic_out_last", 64'(out_last), 64'd1);
        chk("basic_group_done", 64'(group_done), 64'd1);
        tick();

        // Saturation and ReLU corners
        cfg_shift = 5'd2; cfg_relu = 1'b0;
        push_bias(fill(0));
        send_beat(fill(-5000), 1'b1);
        wait_out(64'h8080808080808080, "neg_saturate");
        cfg_relu = 1'b1;
        push_bias(fill(0));
        send_beat(fill(-5000), 1'b1);
        wait_out(64'h0, "relu_zero");
        cfg_shift = 5'd0; cfg_relu = 1'b0;
        push_bias(fill(0));
        send_beat(fill(40000), 1'b1);
        wait_out(64'h7f7f7f7f7f7f7f7f, "pos_saturate");

        // Two queued biases, two groups
        cfg_shift = 5'd6;
        gd_cnt = 0;
        va = rnd_vec(); vb = rnd_vec();
        push_bias(va);
        push_bias(vb);
        @(negedge clk);
        chk("full_bias_ready", 64'(bias_ready), 64'd0);
        tick();
        send_beat(rnd_vec(), 1'b0);
        send_beat(rnd_vec(), 1'b0);
        acc_valid = 1'b1; acc_data = rnd_vec(); acc_last = 1'b1;
        @(negedge clk);
        chk("a_last_bias_ready_low", 64'(bias_ready), 64'd0);
        tick();
        acc_valid = 1'b0; acc_last = 1'b0;
        @(negedge clk);
        chk("bias_ready_after_pop", 64'(bias_ready), 64'd1);
        tick();
        send_beat(rnd_vec(), 1'b0);
        send_beat(rnd_vec(), 1'b1);
        drain();
        chk("group_done_count", 64'(gd_cnt), 64'd2);

        // Output stall with a full pipeline
        cfg_shift = 5'd3;
        vs = rnd_vec();
        a1 = rnd_vec(); a2 = rnd_vec(); a3 = rnd_vec(); a4 = rnd_vec();
        push_bias(vs);
        out_ready = 1'b0;
        send_beat(a1, 1'b0);
        send_beat(a2, 1'b0);
        acc_valid = 1'b1; acc_data = a3; acc_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_out_data", 64'(out_data), 64'(model_vec(a1, vs, 3, 1'b0)));
            chk("stall_acc_ready", 64'(acc_ready), 64'd0);
            tick();
        end
        out_ready = 1'b1;
        send_beat(a3, 1'b0);
        send_beat(a4, 1'b1);
        drain();

        // Flush mid-group with a bias queued
        push_bias(rnd_vec());
        push_bias(rnd_vec());
        send_beat(rnd_vec(), 1'b0);
        send_beat(rnd_vec(), 1'b0);
        cfg_start = 1'b1;
        acc_valid = 1'b1; acc_data = rnd_vec(); acc_last = 1'b1;
        tick();
        cfg_start = 1'b0;
        acc_valid = 1'b0; acc_last = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_bias_ready", 64'(bias_ready), 64'd1);
        chk("flush_acc_ready", 64'(acc_ready), 64'd0);
        tick();
        vs = rnd_vec(); c = rnd_vec();
        push_bias(vs);
        send_beat(c, 1'b1);
        wait_out(model_vec(c, vs, int'(cfg_shift), cfg_relu), "fresh_bias_after_flush");
        drain();

        // Randomised layers with preloaded biases and random back-pressure
        for (int layer = 0; layer < 3; layer++) begin
            cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            cfg_shift = 5'($urandom_range(0, 20));
            cfg_relu  = 1'($urandom_range(0, 1));
            rand_ready = 1'b1;
            push_bias(rnd_vec());
            for (int g = 0; g < 4; g++) begin
                nb = $urandom_range(1, 4);
                for (int k = 0; k < nb - 1; k++) send_beat(rnd_vec(), 1'b0);
                if (g < 3) push_bias(rnd_vec());
                send_beat(rnd_vec(), 1'b1);
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bias_add_quant
`default_nettype wire
